// File: rtl/sap_control_sequencer.sv
// SAP-U microcode sequencer: falling-edge step counter, halt latch, control-word decode.
// Optional JC/JZ decoding is enabled by defining SAP_COND_JUMP_EN.
module sap_control_sequencer #(
  parameter int STEPS = 5
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [3:0]  opcode,
  input  logic        carry_flag,
  input  logic        zero_flag,
  output logic [15:0] ctrl,
  output logic [2:0]  step,
  output logic        halted
);

  localparam logic [2:0] LAST = 3'(STEPS - 1);

  localparam logic [15:0] HLT = 16'h8000;
  localparam logic [15:0] MI  = 16'h4000;
  localparam logic [15:0] RI  = 16'h2000;
  localparam logic [15:0] RO  = 16'h1000;
  localparam logic [15:0] IO  = 16'h0800;
  localparam logic [15:0] II  = 16'h0400;
  localparam logic [15:0] AI  = 16'h0200;
  localparam logic [15:0] AO  = 16'h0100;
  localparam logic [15:0] EO  = 16'h0080;
  localparam logic [15:0] SU  = 16'h0040;
  localparam logic [15:0] BI  = 16'h0020;
  localparam logic [15:0] OI  = 16'h0010;
  localparam logic [15:0] CE  = 16'h0008;
  localparam logic [15:0] CO  = 16'h0004;
  localparam logic [15:0] J   = 16'h0002;
  localparam logic [15:0] FI  = 16'h0001;

  // Stepping on the falling edge gives ctrl a half cycle to settle
  // before the rising edge the 173 registers and PC sample on.
  always_ff @(negedge clk or posedge clr) begin
    if (clr) begin
      step   <= 3'd0;
      halted <= 1'b0;
    end else if (!halted) begin
      if (step == 3'd2 && opcode == 4'hF) begin
        halted <= 1'b1;
      end else if (step == LAST) begin
        step <= 3'd0;
      end else begin
        step <= step + 3'd1;
      end
    end
  end

  logic jc_take;
  logic jz_take;

`ifdef SAP_COND_JUMP_EN
  assign jc_take = carry_flag;
  assign jz_take = zero_flag;
`else
  logic unused_flags;
  assign unused_flags = carry_flag ^ zero_flag;
  assign jc_take = 1'b0;
  assign jz_take = 1'b0;
`endif

  logic [15:0] t2;
  logic [15:0] t3;
  logic [15:0] t4;

  always_comb begin
    t2 = '0;
    t3 = '0;
    t4 = '0;
    unique case (opcode)
      4'h1: begin
        t2 = IO | MI;
        t3 = RO | AI;
      end
      4'h2: begin
        t2 = IO | MI;
        t3 = RO | BI;
        t4 = EO | AI | FI;
      end
      4'h3: begin
        t2 = IO | MI;
        t3 = RO | BI;
        t4 = EO | AI | SU | FI;
      end
      4'h4: begin
        t2 = IO | MI;
        t3 = AO | RI;
      end
      4'h5: t2 = IO | AI;
      4'h6: t2 = IO | J;
      4'h7: t2 = jc_take ? (IO | J) : '0;
      4'h8: t2 = jz_take ? (IO | J) : '0;
      4'hE: t2 = AO | OI;
      4'hF: t2 = HLT;
      default: ;
    endcase
  end

  // Reset forces the fetch word off so nothing loads while clr is high.
  always_comb begin
    ctrl = '0;
    if (clr) begin
      ctrl = '0;
    end else if (halted) begin
      ctrl = HLT;
    end else begin
      unique case (step)
        3'd0: ctrl = CO | MI;
        3'd1: ctrl = RO | II | CE;
        3'd2: ctrl = t2;
        3'd3: ctrl = t3;
        3'd4: ctrl = t4;
        default: ctrl = '0;
      endcase
    end
  end

endmodule

// File: doc/sap_control_sequencer.md
# sap_control_sequencer

Microcode control sequencer for the SAP-U CPU. It consumes the opcode nibble held in the instruction register (an sn54173 quad flip-flop) and steps through five T-states per instruction. In each T-state it drives the control word that gates loads and bus outputs on the 173-based A, B, MAR, IR and output registers, the RAM, the ALU and the program counter.

## Interface
Parameters:
- `STEPS`, default 5. Number of T-states per instruction. Legal values are 5 to 8. The step counter wraps from `STEPS-1` to 0.

Ports (clock and reset first):
- `clk` in 1. System clock. The step counter and halt latch advance on its falling edge.
- `clr` in 1. Reset, asynchronous, active-high.
- `opcode` in 4. IR upper nibble.
- `carry_flag` in 1. Registered carry from the flags register.
- `zero_flag` in 1. Registered zero from the flags register.
- `ctrl` out 16. Control word, all bits active-high. Top level inverts bits feeding active-low 173 `g1/g2`/`m/n` pins. Bit assignment:
  - 15 hlt
  - 14 mi
  - 13 ri
  - 12 ro
  - 11 io
  - 10 ii
  - 9 ai
  - 8 ao
  - 7 eo
  - 6 su
  - 5 bi
  - 4 oi
  - 3 ce
  - 2 co
  - 1 j
  - 0 fi
- `step` out 3. Current T-state, 0 to `STEPS-1`.
- `halted` out 1. Halt latch.

## Operation
- State: 3-bit step counter and 1-bit halt latch. `ctrl` is a combinational decode of `{halted, step, opcode, flags}`.
- Fetch:
  - T0: co|mi.
  - T1: ro|ii|ce. Identical for every opcode.
- Execute words for T2, T3 and T4. Steps not listed are 0.
  - 0000 NOP: none.
  - 0001 LDA: T2 io|mi. T3 ro|ai.
  - 0010 ADD: T2 io|mi. T3 ro|bi. T4 eo|ai|fi.
  - 0011 SUB: T2 io|mi. T3 ro|bi. T4 eo|ai|su|fi.
  - 0100 STA: T2 io|mi. T3 ao|ri.
  - 0101 LDI: T2 io|ai.
  - 0110 JMP: T2 io|j.
  - 0111 JC: T2 io|j when `carry_flag`=1, otherwise none.
  - 1000 JZ: T2 io|j when `zero_flag`=1, otherwise none.
  - 1110 OUT: T2 ao|oi.
  - 1111 HLT: T2 hlt.
  - Any other opcode decodes as NOP.
- Steps ≥5, which exist only when `STEPS`>5, decode to 0.
- Halt:
  - On the falling edge while step=2 and opcode=1111, `halted` sets and step holds at 2.
  - While `halted`=1, `ctrl`=16'h8000 regardless of `opcode` and flags.
  - Only `clr` exits halt.
- Flags are sampled combinationally during T2. The sequencer does not latch them.

## Timing
- Reset: while `clr`=1, step=0, `halted`=0 and `ctrl`=16'h0000. The T0 word is forced off so no register loads during reset.
- After `clr` falls, `ctrl`=16'h4004 (co|mi) immediately. The first step advance happens on the next falling edge.
- The step counter changes on the negedge of `clk`, so `ctrl` is stable for a half cycle before the rising edge on which the 173 registers and PC sample. Effective latency from step change to register load is one half-cycle.
- Wrap: step `STEPS-1` goes to 0 on the next negedge. One instruction takes exactly `STEPS` clocks, including NOP and untaken jumps. There is no early termination.
- Opcode changes mid-instruction take effect combinationally. The IR only loads at T1, so `opcode` is stable for T2 onward.
- `clr` asserted mid-instruction or while halted: step, `halted` and `ctrl` clear asynchronously within the same cycle.
- `clr` released coincident with a negedge: step stays 0 for that edge.

## Configuration
- Macro: `SAP_COND_JUMP_EN`.
  - Defined: JC (0111) and JZ (1000) decode as listed under Operation.
  - Undefined: 0111 and 1000 decode as NOP, the `carry_flag`/`zero_flag` inputs remain but are ignored, and `fi` is still generated by ADD/SUB.

## Test plan
- Reset sequence: hold `clr`=1 for 15 ns, then release, with `opcode`=0001 → `ctrl`=0000 during reset. After release the words are 4004, 1408, 4800, 1200, 0000, then 4004 again. `step` counts 0,1,2,3,4,0.
- ADD vs SUB: at T4, `opcode`=0010 gives `ctrl`=0281 and `opcode`=0011 gives 02C1. At T3 both give 1020.
- HLT: `opcode`=1111 → `halted`=1 after the T2 negedge, `ctrl`=8000 and `step`=2 for 20 cycles. Changing `opcode` to 0001 leaves `ctrl` at 8000. Asserting `clr` returns `ctrl` to 0000 and `halted` to 0.
- Conditional jump (with `SAP_COND_JUMP_EN` defined): JC at T2 gives 0802 with carry=1 and 0000 with carry=0. JZ at T2 gives 0802 with zero=1. Rebuilt without the macro, both give 0000.
- Reset mid-instruction: assert `clr` at step=3 of STA → `step`=0 and `ctrl`=0000 within 1 ns. After release, `ctrl`=4004.
- Undefined opcode 1010 → T2, T3 and T4 all give 0000, and the instruction still takes 5 clocks.
